// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage.
// Owns the PC, drives a synchronous instruction memory (read data returns one
// cycle after imem_addr), and presents instr_d/pc_d/pcplus4_d/valid_d to decode.
// Decode stalls use a one-entry hold buffer; execute redirects cost one bubble.
// Optional feature macro: FETCH_PERF_EN adds the fetch_cnt/bubble_cnt counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FILL, RUN, HOLD, FLUSH} state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] pc_if;       // address issued last cycle, i.e. the PC of imem_rdata
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  assign imem_addr = pc_f;

  // PC sequencing, FSM and hold-buffer capture; valid_d is registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      valid_d    <= 1'b0;
      pc_f       <= RESET_PC;
      pc_if      <= RESET_PC;
      hold_instr <= NOP;
      hold_pc    <= '0;
    end else begin
      // imem is read every cycle, so the PC of next cycle's read data is
      // always this cycle's pc_f, whether or not pc_f moves.
      pc_if <= pc_f;
      if (pc_src_e) begin
        pc_f    <= {pc_target_e[31:2], 2'b00};
        state   <= FLUSH;
        valid_d <= 1'b0;
      end else if (stall_d && valid_d) begin
        if (state == RUN) begin
          hold_instr <= imem_rdata;
          hold_pc    <= pc_if;
        end
        state   <= HOLD;
        valid_d <= 1'b1;
      end else begin
        pc_f    <= pc_f + 32'd4;
        state   <= RUN;
        valid_d <= 1'b1;
      end
    end
  end

  // Decode-side mux: live memory word in RUN, hold buffer in HOLD, NOP bubble otherwise
  always_comb begin
    instr_d = NOP;
    pc_d    = '0;
    case (state)
      RUN: begin
        instr_d = imem_rdata;
        pc_d    = pc_if;
      end
      HOLD: begin
        instr_d = hold_instr;
        pc_d    = hold_pc;
      end
      default: ;
    endcase
  end

  assign pcplus4_d = pc_d + 32'd4;

`ifdef FETCH_PERF_EN
  // Performance counters: delivered instructions and bubble cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (valid_d && !stall_d) fetch_cnt <= fetch_cnt + 32'd1;
      if (!valid_d) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table of cycle vectors plus randomized stimulus,
// all checked against a behavioural model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_d = 1'b0;
  logic        pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;

  logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pcplus4_d;
  logic        valid_d;
  logic [31:0] imem_addr2, imem_rdata2, instr_d2, pc_d2, pcplus4_d2;
  logic        valid_d2;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt2, bubble_cnt2;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .stall_d(1'b0), .pc_src_e(1'b0), .pc_target_e(32'h0),
    .instr_d(instr_d2), .pc_d(pc_d2), .pcplus4_d(pcplus4_d2), .valid_d(valid_d2)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt2), .bubble_cnt(bubble_cnt2)
`endif
  );

  // Instruction memory contents: two fixed words, a scrambled address elsewhere
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  always @(posedge clk) begin
    imem_rdata  <= word(imem_addr);
    imem_rdata2 <= word(imem_addr2);
  end

  // Behavioural model: what decode sees next cycle, and the address being fetched
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_pcf;
  logic [31:0] m_fetch, m_bubble;

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_pcf = 32'h0; m_fetch = '0; m_bubble = '0;
  endtask

  task automatic model_step(input logic st, input logic src, input logic [31:0] tgt);
    if (m_valid && !st) m_fetch = m_fetch + 1;
    if (!m_valid) m_bubble = m_bubble + 1;
    if (src) begin
      m_valid = 1'b0;
      m_pcf = tgt & 32'hFFFF_FFFC;
    end else if (!(st && m_valid)) begin
      m_valid = 1'b1;
      m_pc = m_pcf;
      m_pcf = m_pcf + 32'd4;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, m_valid});
    check({tag, ".imem_addr"}, imem_addr, m_pcf);
    if (m_valid) begin
      check({tag, ".pc_d"}, pc_d, m_pc);
      check({tag, ".instr_d"}, instr_d, word(m_pc));
      check({tag, ".pcplus4_d"}, pcplus4_d, m_pc + 32'd4);
    end
`ifdef FETCH_PERF_EN
    check({tag, ".fetch_cnt"}, fetch_cnt, m_fetch);
    check({tag, ".bubble_cnt"}, bubble_cnt, m_bubble);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_d = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid_d", {31'd0, valid_d}, 32'd0);
    check("rst.instr_d", instr_d, NOP);
    check("rst.pc_d", pc_d, 32'h0);
    check("rst.pcplus4_d", pcplus4_d, 32'h4);
    check("rst.imem_addr", imem_addr, 32'h0);
    check("rst.wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        st;
    logic        src;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'h4,   1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   32'h8,   1'b1, 32'h4};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'hC,   1'b1, 32'h8};
    vecs[7]  = '{1'b0, 1'b1, 32'h40,  32'h10,  1'b1, 32'hC};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   32'h40,  1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h80,  32'h44,  1'b1, 32'h40};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h80,  1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h103, 32'h84,  1'b1, 32'h80};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   32'h100, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,   32'h104, 1'b1, 32'h100};
    vecs[14] = '{1'b1, 1'b0, 32'h0,   32'h104, 1'b1, 32'h100};

    do_reset();

    // Directed sequence: fill, stall/hold, redirects, redirect-vs-stall, misaligned target
    for (int i = 0; i < 15; i++) begin
      stall_d = vecs[i].st; pc_src_e = vecs[i].src; pc_target_e = vecs[i].tgt;
      #4;
      check($sformatf("vec%0d.valid_d", i), {31'd0, valid_d}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d.pc_d", i), pc_d, vecs[i].e_pc);
        check($sformatf("vec%0d.instr_d", i), instr_d, word(vecs[i].e_pc));
        check($sformatf("vec%0d.pcplus4_d", i), pcplus4_d, vecs[i].e_pc + 32'd4);
      end
      compare_model($sformatf("vec%0d.model", i));
      if (i == 1) begin
        check("wrap.valid_d", {31'd0, valid_d2}, 32'd1);
        check("wrap.pc_d", pc_d2, 32'hFFFF_FFFC);
        check("wrap.pcplus4_d", pcplus4_d2, 32'h0);
      end
      if (i == 2) begin
        check("wrap2.pc_d", pc_d2, 32'h0);
        check("wrap2.instr_d", instr_d2, 32'h0050_0093);
      end
      if (i < 14) begin
        @(posedge clk);
        model_step(vecs[i].st, vecs[i].src, vecs[i].tgt);
        #1;
      end
    end

    // Reset asserted while holding: outputs return to reset values immediately
    rst_n = 1'b0;
    #1;
    check("hold_rst.valid_d", {31'd0, valid_d}, 32'd0);
    check("hold_rst.imem_addr", imem_addr, 32'h0);
    check("hold_rst.instr_d", instr_d, NOP);
    check("hold_rst.pc_d", pc_d, 32'h0);
`ifdef FETCH_PERF_EN
    check("hold_rst.fetch_cnt", fetch_cnt, 32'h0);
    check("hold_rst.bubble_cnt", bubble_cnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    do_reset();

    // Randomized stimulus with one reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      stall_d = ($urandom_range(0, 9) < 4);
      pc_src_e = ($urandom_range(0, 9) == 0);
      pc_target_e = $urandom;
      #4;
      compare_model($sformatf("rnd%0d", i));
      @(posedge clk);
      model_step(stall_d, pc_src_e, pc_target_e);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
